// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator engine.
//   op_e      : operation codes carried on op_o (add, sub, mul, div)
//   state_e   : sequencer states
//   BTN_*     : bit positions of each key in the one-hot button level
//   btn_to_op : fixed-priority encode of key rising edges (add > sub > mul > div)
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BTN_ADD = 3;
  localparam int BTN_SUB = 2;
  localparam int BTN_MUL = 1;
  localparam int BTN_DIV = 0;

  // Several keys may rise in the same cycle; the highest-priority one wins.
  function automatic op_e btn_to_op(input logic [3:0] rise);
    op_e op;
    if (rise[BTN_ADD]) begin
      op = OP_ADD;
    end else if (rise[BTN_SUB]) begin
      op = OP_SUB;
    end else if (rise[BTN_MUL]) begin
      op = OP_MUL;
    end else begin
      op = OP_DIV;
    end
    return op;
  endfunction

endpackage

// File: rtl/calc_muldiv_iter.sv
// calc_muldiv_iter: iterative unsigned multiplier / restoring divider.
// One result bit per cycle, WIDTH cycles per operation. Both modes share the
// same {hi, lo} register pair and bit counter:
//   mul: hi = partial product upper half, lo = multiplier shifting out
//   div: hi = partial remainder,          lo = dividend shifting into quotient
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   start_i    : load operands and begin (overrides any run in progress)
//   mode_i     : 0 = multiply, 1 = divide
//   a_i, b_i   : operands (div: a_i dividend, b_i divisor, b_i != 0)
//   done_o     : one-cycle pulse during the last iteration
//   res_o      : product or zero-extended quotient, valid while done_o
//   rem_o      : remainder (0 in multiply mode), valid while done_o
module calc_muldiv_iter
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] res_o,
  output logic [WIDTH-1:0]   rem_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             r_run;
  logic             r_mode;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_n;
  logic [WIDTH-1:0] w_lo_n;

  // Remainder stays below the divisor, so a non-negative trial difference
  // always fits in WIDTH bits and modular subtraction is exact.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[WIDTH-1:0] - r_b;

  // Next value of the shared hi/lo pair for one iteration of either mode.
  always_comb begin
    w_hi_n = r_hi;
    w_lo_n = r_lo;
    if (r_mode) begin
      w_hi_n = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Final values are taken from the next-state terms so the caller can
  // capture them on the same edge as the last iteration.
  assign done_o = r_run && (r_cnt == CW'(WIDTH-1));
  assign res_o  = r_mode ? {{WIDTH{1'b0}}, w_lo_n} : {w_hi_n, w_lo_n};
  assign rem_o  = r_mode ? w_hi_n : {WIDTH{1'b0}};

  // Operand load and per-cycle iteration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run  <= 1'b0;
      r_mode <= 1'b0;
      r_cnt  <= {CW{1'b0}};
      r_hi   <= {WIDTH{1'b0}};
      r_lo   <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
    end else if (start_i) begin
      r_run  <= 1'b1;
      r_mode <= mode_i;
      r_cnt  <= {CW{1'b0}};
      r_hi   <= {WIDTH{1'b0}};
      r_lo   <= a_i;
      r_b    <= b_i;
    end else if (r_run) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + CW'(1);
      if (done_o) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_engine.sv
// calc_engine: key-edge operation sequencer with add/sub/mul/div ALU.
// A new rising key (one-hot level on btn_i) in IDLE or DONE captures a_i/b_i
// and starts an op; add/sub/div-by-zero finish in one CALC cycle, mul/div
// run WIDTH cycles in calc_muldiv_iter. Results update only on entry to DONE.
// Optional feature macro: CALC_OVF_EN adds ovf_o (add carry / product >= 2^WIDTH).
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   btn_i     : key level [3]=add [2]=sub [1]=mul [0]=div
//   a_i, b_i  : unsigned operands
//   busy_o    : computing
//   valid_o   : result registers hold a completed result
//   op_o      : op of held result
//   result_o  : sum / |difference| / product / quotient
//   rem_o     : division remainder, 0 otherwise
//   neg_o     : subtraction with A < B
//   div0_o    : division by zero
//   ovf_o     : (CALC_OVF_EN only) result wider than WIDTH bits
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         btn_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic [1:0]         op_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic [WIDTH-1:0]   rem_o,
  output logic               neg_o,
  output logic               div0_o
`ifdef CALC_OVF_EN
  ,
  output logic               ovf_o
`endif
);

  localparam int RW = 2 * WIDTH;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [3:0]       r_btn_prev;
  op_e              r_op_lat;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             r_busy;
  logic             r_valid;
  op_e              r_op;
  logic [RW-1:0]    r_result;
  logic [WIDTH-1:0] r_rem;
  logic             r_neg;
  logic             r_div0;

  logic [3:0]       w_rise;
  logic             w_start;
  op_e              w_new_op;
  logic             w_calc_done;
  logic [WIDTH:0]   w_sum;
  logic [RW-1:0]    w_result_n;
  logic [WIDTH-1:0] w_rem_n;
  logic             w_neg_n;
  logic             w_div0_n;

  logic             w_md_done;
  logic [RW-1:0]    w_md_res;
  logic [WIDTH-1:0] w_md_rem;

`ifdef CALC_OVF_EN
  logic             r_ovf;
  logic             w_ovf_n;
  assign ovf_o = r_ovf;
`endif

  // Edges arriving during CALC are consumed by btn_prev and thus dropped.
  assign w_rise   = btn_i & ~r_btn_prev;
  assign w_start  = (|w_rise) && ((r_state == IDLE) || (r_state == DONE));
  assign w_new_op = btn_to_op(w_rise);
  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};

  calc_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (w_start && ((w_new_op == OP_MUL) || (w_new_op == OP_DIV))),
    .mode_i  (w_new_op == OP_DIV),
    .a_i     (a_i),
    .b_i     (b_i),
    .done_o  (w_md_done),
    .res_o   (w_md_res),
    .rem_o   (w_md_rem)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_start ? CALC : IDLE;
      CALC:    w_state_nxt = w_calc_done ? DONE : CALC;
      DONE:    w_state_nxt = w_start ? CALC : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Completion condition and result values for the op being computed.
  always_comb begin
    w_calc_done = 1'b0;
    w_result_n  = r_result;
    w_rem_n     = {WIDTH{1'b0}};
    w_neg_n     = 1'b0;
    w_div0_n    = 1'b0;
`ifdef CALC_OVF_EN
    w_ovf_n     = 1'b0;
`endif
    case (r_op_lat)
      OP_ADD: begin
        w_calc_done = 1'b1;
        w_result_n  = {{(RW-WIDTH-1){1'b0}}, w_sum};
`ifdef CALC_OVF_EN
        w_ovf_n     = w_sum[WIDTH];
`endif
      end
      OP_SUB: begin
        w_calc_done = 1'b1;
        if (r_a >= r_b) begin
          w_result_n = {{WIDTH{1'b0}}, r_a - r_b};
          w_neg_n    = 1'b0;
        end else begin
          w_result_n = {{WIDTH{1'b0}}, r_b - r_a};
          w_neg_n    = 1'b1;
        end
      end
      OP_MUL: begin
        w_calc_done = w_md_done;
        w_result_n  = w_md_res;
`ifdef CALC_OVF_EN
        w_ovf_n     = |w_md_res[RW-1:WIDTH];
`endif
      end
      OP_DIV: begin
        if (r_b == {WIDTH{1'b0}}) begin
          w_calc_done = 1'b1;
          w_result_n  = {RW{1'b0}};
          w_rem_n     = r_a;
          w_div0_n    = 1'b1;
        end else begin
          w_calc_done = w_md_done;
          w_result_n  = w_md_res;
          w_rem_n     = w_md_rem;
        end
      end
      default: begin
        w_calc_done = 1'b1;
      end
    endcase
  end

  // Operand capture, status registers and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_btn_prev <= 4'b1111;
      r_op_lat   <= OP_ADD;
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_op       <= OP_ADD;
      r_result   <= {RW{1'b0}};
      r_rem      <= {WIDTH{1'b0}};
      r_neg      <= 1'b0;
      r_div0     <= 1'b0;
`ifdef CALC_OVF_EN
      r_ovf      <= 1'b0;
`endif
    end else begin
      r_btn_prev <= btn_i;
      r_busy     <= (w_state_nxt == CALC);
      r_valid    <= (w_state_nxt == DONE);
      if (w_start) begin
        r_a      <= a_i;
        r_b      <= b_i;
        r_op_lat <= w_new_op;
        r_neg    <= 1'b0;
        r_div0   <= 1'b0;
`ifdef CALC_OVF_EN
        r_ovf    <= 1'b0;
`endif
      end else if ((r_state == CALC) && w_calc_done) begin
        r_op     <= r_op_lat;
        r_result <= w_result_n;
        r_rem    <= w_rem_n;
        r_neg    <= w_neg_n;
        r_div0   <= w_div0_n;
`ifdef CALC_OVF_EN
        r_ovf    <= w_ovf_n;
`endif
      end
    end
  end

  assign busy_o   = r_busy;
  assign valid_o  = r_valid;
  assign op_o     = r_op;
  assign result_o = r_result;
  assign rem_o    = r_rem;
  assign neg_o    = r_neg;
  assign div0_o   = r_div0;

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: table-driven, hand-sequenced and randomized checks of
// calc_engine (WIDTH=8) against expected values derived from plain arithmetic.
module tb_calc_engine;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [3:0]     btn_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           busy_o;
  logic           valid_o;
  logic [1:0]     op_o;
  logic [2*W-1:0] result_o;
  logic [W-1:0]   rem_o;
  logic           neg_o;
  logic           div0_o;
`ifdef CALC_OVF_EN
  logic           ovf_o;
`endif

  int n_pass;
  int n_total;

  calc_engine #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .op_o     (op_o),
    .result_o (result_o),
    .rem_o    (rem_o),
    .neg_o    (neg_o),
    .div0_o   (div0_o)
`ifdef CALC_OVF_EN
    ,
    .ovf_o    (ovf_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    int         a;
    int         b;
    int         hold;
    int         op;
    int         res;
    int         rem;
    int         neg;
    int         div0;
    int         ovf;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Present an op at the next edge and watch outputs on falling edges.
  // lat = falling edges after the start edge until valid_o (0 = timeout).
  task automatic apply(input logic [3:0] btn, input int a, input int b, input int hold,
                       output int lat, output int bcnt);
    a_i   = a[W-1:0];
    b_i   = b[W-1:0];
    btn_i = btn;
    lat   = 0;
    bcnt  = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy_o) bcnt++;
      if (valid_o && (lat == 0)) lat = k;
      if ((lat != 0) && (k >= hold)) break;
    end
    btn_i = 4'b0000;
    @(negedge clk);
  endtask

  // Reference behaviour from the arithmetic definition of each operation.
  task automatic model(input logic [3:0] btn, input int a, input int b,
                       output int op, output int res, output int rem, output int neg,
                       output int div0, output int ovf, output int lat);
    if (btn[3]) op = 0;
    else if (btn[2]) op = 1;
    else if (btn[1]) op = 2;
    else op = 3;
    res = 0; rem = 0; neg = 0; div0 = 0; ovf = 0; lat = 2;
    case (op)
      0: begin res = a + b; ovf = (res > 255) ? 1 : 0; end
      1: begin res = (a >= b) ? a - b : b - a; neg = (a < b) ? 1 : 0; end
      2: begin res = a * b; ovf = (res > 255) ? 1 : 0; lat = W + 1; end
      default: begin
        if (b == 0) begin
          res = 0; rem = a; div0 = 1;
        end else begin
          res = a / b; rem = a % b; lat = W + 1;
        end
      end
    endcase
  endtask

  task automatic check_result(input string tag, input int lat, input int bcnt,
                              input int op, input int res, input int rem, input int neg,
                              input int div0, input int ovf, input int elat);
    check({tag, "_lat"},  lat, elat);
    check({tag, "_busy"}, bcnt, elat - 1);
    check({tag, "_op"},   op_o, op);
    check({tag, "_res"},  result_o, res);
    check({tag, "_rem"},  rem_o, rem);
    check({tag, "_neg"},  neg_o, neg);
    check({tag, "_div0"}, div0_o, div0);
`ifdef CALC_OVF_EN
    check({tag, "_ovf"},  ovf_o, ovf);
`endif
  endtask

  initial begin
    int lat, bcnt, eop, eres, erem, eneg, ediv0, eovf, elat;
    logic [3:0] rb;
    int ra, rbv;

    n_pass  = 0;
    n_total = 0;

    //            btn      a    b   hold op  res   rem neg d0 ovf lat
    vecs[0]  = '{4'b1000, 200, 100, 40, 0,   300,   0, 0, 0, 1, 2};
    vecs[1]  = '{4'b0100,   5,   9,  1, 1,     4,   0, 1, 0, 0, 2};
    vecs[2]  = '{4'b0100,   9,   5,  1, 1,     4,   0, 0, 0, 0, 2};
    vecs[3]  = '{4'b0001, 100,   7,  1, 3,    14,   2, 0, 0, 0, 9};
    vecs[4]  = '{4'b0001, 100,   0,  1, 3,     0, 100, 0, 1, 0, 2};
    vecs[5]  = '{4'b0110,   5,   3,  1, 1,     2,   0, 0, 0, 0, 2};
    vecs[6]  = '{4'b1111,   3,   4,  1, 0,     7,   0, 0, 0, 0, 2};
    vecs[7]  = '{4'b0011,   6,   7,  1, 2,    42,   0, 0, 0, 0, 9};
    vecs[8]  = '{4'b0010,  16,  16,  1, 2,   256,   0, 0, 0, 1, 9};
    vecs[9]  = '{4'b1000, 255,   1,  1, 0,   256,   0, 0, 0, 1, 2};
    vecs[10] = '{4'b1000, 254,   1,  1, 0,   255,   0, 0, 0, 0, 2};
    vecs[11] = '{4'b0001, 255, 255,  1, 3,     1,   0, 0, 0, 0, 9};

    rst   = 1'b0;
    btn_i = 4'b0000;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   busy_o, 0);
    check("rst_valid",  valid_o, 0);
    check("rst_op",     op_o, 0);
    check("rst_result", result_o, 0);
    check("rst_rem",    rem_o, 0);
    check("rst_flags",  {neg_o, div0_o}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].btn, vecs[i].a, vecs[i].b, vecs[i].hold, lat, bcnt);
      check_result($sformatf("vec%0d", i), lat, bcnt, vecs[i].op, vecs[i].res,
                   vecs[i].rem, vecs[i].neg, vecs[i].div0, vecs[i].ovf, vecs[i].lat);
    end

    // Multiply with a divide key rising mid-computation: the edge is dropped.
    a_i = 8'd255; b_i = 8'd255; btn_i = 4'b0010;
    lat = 0; bcnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) btn_i = 4'b0011;
      if (busy_o) bcnt++;
      if (valid_o) begin
        lat = k;
        break;
      end
    end
    check("mulblk_lat",  lat, 9);
    check("mulblk_busy", bcnt, 8);
    check("mulblk_res",  result_o, 65025);
    check("mulblk_op",   op_o, 2);
    repeat (12) @(negedge clk);
    check("mulblk_hold_valid", valid_o, 1);
    check("mulblk_hold_res",   result_o, 65025);
    check("mulblk_hold_busy",  busy_o, 0);
    btn_i = 4'b0000;
    @(negedge clk);

    // Reset during a multiply with the key held: abort, no re-fire after release.
    a_i = 8'd12; b_i = 8'd13; btn_i = 4'b0010;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy",   busy_o, 0);
    check("midrst_valid",  valid_o, 0);
    check("midrst_result", result_o, 0);
    check("midrst_op",     op_o, 0);
    rst = 1'b1;
    bcnt = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (busy_o || valid_o) bcnt++;
    end
    check("midrst_no_refire", bcnt, 0);
    btn_i = 4'b0000;
    @(negedge clk);
    apply(4'b0010, 12, 13, 1, lat, bcnt);
    check_result("after_rst", lat, bcnt, 2, 156, 0, 0, 0, 0, 9);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rb  = 4'($urandom_range(1, 15));
      ra  = int'($urandom_range(0, 255));
      rbv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      model(rb, ra, rbv, eop, eres, erem, eneg, ediv0, eovf, elat);
      apply(rb, ra, rbv, 1, lat, bcnt);
      check_result($sformatf("rnd%0d", i), lat, bcnt, eop, eres, erem, eneg, ediv0, eovf, elat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
